// File: rtl/bp_network_deserializer_if.sv
// Flit-in / message-out handshake bundle for the network deserializer.
// master is the environment side (producer + consumer), slave is the deserializer.
interface bp_network_deserializer_if #(
  parameter int unsigned flit_width_p = 24,
  parameter int unsigned data_width_p = 40
);
  logic                    valid_i;
  logic [flit_width_p-1:0] data_i;
  logic                    ready_o;
  logic                    valid_o;
  logic [data_width_p-1:0] data_o;
  logic                    mismatch_o;
  logic                    yumi_i;

  modport master (
    output valid_i, data_i, yumi_i,
    input  ready_o, valid_o, data_o, mismatch_o
  );

  modport slave (
    input  valid_i, data_i, yumi_i,
    output ready_o, valid_o, data_o, mismatch_o
  );
endinterface

// File: rtl/bp_network_deserializer.sv
// Reassembles N narrow {dest, src, payload} flits (LSB chunk first) into one wide
// message, presented on valid/yumi with a header-consistency flag.
module bp_network_deserializer #(
  parameter int unsigned dest_id_width_p     = 4,
  parameter int unsigned src_id_width_p      = 4,
  parameter int unsigned source_data_width_p = 40,
  parameter int unsigned packet_data_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  bp_network_deserializer_if.slave     bus
);
  localparam int unsigned P  = packet_data_width_p;
  localparam int unsigned S  = source_data_width_p;
  localparam int unsigned H  = dest_id_width_p + src_id_width_p;
  localparam int unsigned N  = S / P + 1;
  localparam int unsigned T  = P * N;
  localparam int unsigned F  = P + H;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [T-1:0]    asm_q, asm_d;
  logic [H-1:0]    hdr_q, hdr_d;
  logic            err_q, err_d;

  logic            accept;
  logic [H-1:0]    flit_hdr;
  logic [P-1:0]    flit_pay;

  assign flit_hdr = bus.data_i[F-1 -: H];
  assign flit_pay = bus.data_i[P-1:0];
  assign accept   = bus.valid_i & bus.ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      asm_q   <= '0;
      hdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      hdr_q   <= hdr_d;
      err_q   <= err_d;
    end
  end

  // Next-state: collect chunks into the slot selected by the flit count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    hdr_d   = hdr_q;
    err_d   = err_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) asm_d[k*P +: P] = flit_pay;
          end
          if (cnt_q == '0) begin
            hdr_d = flit_hdr;
            err_d = 1'b0;
          end else begin
            err_d = err_q | (flit_hdr != hdr_q);
          end
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (bus.yumi_i) begin
          // A flit arriving with yumi starts the next message immediately.
          if (accept) begin
            asm_d[P-1:0] = flit_pay;
            hdr_d        = flit_hdr;
            err_d        = 1'b0;
            if (N == 1) begin
              cnt_d   = '0;
              state_d = FULL;
            end else begin
              cnt_d   = CW'(1);
              state_d = COLLECT;
            end
          end else begin
            cnt_d   = '0;
            state_d = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.ready_o    = (state_q != FULL) | bus.yumi_i;
  assign bus.valid_o    = (state_q == FULL);
  assign bus.data_o     = asm_q[S-1:0];
  // The serializer copies the header from the message's top bits, so they must agree.
  assign bus.mismatch_o = err_q | (hdr_q != asm_q[S-1 -: H]);
endmodule

// File: doc/bp_network_deserializer.md
# bp_network_deserializer

Receive-side counterpart of `bp_network_serializer`. It accepts the stream of narrow network flits, each carrying a `{dest_id, src_id, payload}` header plus payload chunk, and reassembles them into one wide message of `source_data_width_p` bits. It presents the message on a valid/yumi output and flags header inconsistencies. It sits directly downstream of the network, in front of the consuming ME/cache-side logic.

## Interface
Parameters:
- `dest_id_width_p`, "inv": destination ID width (D).
- `src_id_width_p`, "inv": source ID width (Sr).
- `source_data_width_p`, "inv": reassembled message width (S).
- `packet_data_width_p`, "inv": payload bits per flit (P).
- `num_packets_p`, localparam, `S/P + 1`: flits per message (N). Integer division, matching the serializer.
- `total_data_width`, localparam, `P*N`: padded message width (T).
- `flit_width`, localparam, `P+D+Sr`: flit width (F).

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: synchronous, active-low reset. The block is in reset when `reset_i`==0 at a rising edge of `clk_i`.
- `valid_i`, in, 1: flit valid.
- `data_i`, in, F: flit. Bits `[F-1 -: D]` are dest, the next Sr bits are src, and `[P-1:0]` is the payload.
- `ready_o`, out, 1: block can accept a flit. A flit transfers when `valid_i & ready_o`.
- `valid_o`, out, 1: a reassembled message is available.
- `data_o`, out, S: the reassembled message.
- `mismatch_o`, out, 1: header error for the presented message. Only meaningful while `valid_o` is high.
- `yumi_i`, in, 1: consumer takes the message this cycle. Only legal while `valid_o` is high.

## Operation
- Storage:
  - T-bit assembly register.
  - Flit counter `cnt_r` of width `$clog2(N+1)`, range 0..N-1.
  - Header register `hdr_r` of width D+Sr.
  - Sticky `hdr_err_r`.
  - `full_r` flag.
- States:
  - COLLECT (`full_r`=0).
  - FULL (`full_r`=1).
- Flit k of a message (k=0 first) carries padded bits `[k*P +: P]`, so chunks arrive LSB first.
- In COLLECT, on each accepted flit:
  - Write the payload into the assembly register at slice `cnt_r*P`.
  - If `cnt_r`==0: load `hdr_r` from the flit header and clear `hdr_err_r`.
  - Else: OR `(flit header != hdr_r)` into `hdr_err_r`.
  - If `cnt_r`==N-1: set `cnt_r`=0 and go to FULL. Otherwise increment `cnt_r`.
- Outputs:
  - `data_o` = assembly register `[S-1:0]`. The padding bits `[T-1:S]` are ignored.
  - `mismatch_o` = `hdr_err_r` | (`hdr_r` != `data_o[S-1 -: D+Sr]`). The header must equal the top bits of the message, since the serializer derives it from there.
  - `valid_o` = `full_r`.
- Ready rule: `ready_o` = ~`full_r` | `yumi_i`.
- In FULL:
  - `yumi_i` with no accepted flit returns the block to COLLECT with `cnt_r`=0.
  - `yumi_i` together with an accepted flit treats that flit as flit 0 of the next message: write chunk 0, load `hdr_r`, clear `hdr_err_r`, set `cnt_r`=1, and go to COLLECT.
  - If N==1, that flit completes the next message and the block stays in FULL.
- While in FULL without `yumi_i`: the assembly register, `hdr_r`, `hdr_err_r` and `cnt_r` hold.
- `yumi_i` while `valid_o`==0 is ignored. There is no state change.
- `valid_i` while `ready_o`==0 is not accepted. `data_i` is ignored.

## Timing
- Reset (`reset_i`==0 at a clock edge):
  - `cnt_r`=0, `full_r`=0, `hdr_r`=0, `hdr_err_r`=0, assembly register=0.
  - Hence `valid_o`=0, `data_o`=0, `mismatch_o`=0, `ready_o`=1 from the following cycle.
- Reset mid-message discards all collected flits. It has priority over any simultaneous handshake.
- Latency: if the last flit is accepted at edge t, `valid_o` is 1 in the cycle after t, with `data_o` and `mismatch_o` stable.
- Inter-flit gaps (`valid_i`=0) are allowed at any count and do not change state.
- Throughput: one message per N cycles when the consumer asserts `yumi_i` in the first `valid_o` cycle and the producer streams flits back to back.
- `ready_o` depends combinationally on `yumi_i`. `valid_o`, `data_o` and `mismatch_o` come from registers only.

## Test plan
Use D=4, Sr=4, S=40, P=16, giving N=3, T=48, F=24.
- Reset: hold `reset_i`=0 for 3 cycles, then release -> `valid_o`=0, `data_o`=0, `mismatch_o`=0, `ready_o`=1.
- Basic reassembly: send flits 0xA55678, 0xA51234, 0xA500A5 on consecutive cycles, with `yumi_i` held 0 -> the cycle after the third flit, `valid_o`=1, `data_o`=0xA512345678, `mismatch_o`=0, `ready_o`=0. The outputs hold for 5 idle cycles.
- Backpressure and overlap: while in FULL, present flit 0x3C0001 with `yumi_i`=1 in the same cycle -> the flit is accepted, `valid_o`=0 next cycle, and `cnt_r`=1. Then send 0x3C0002 and 0x3C003C -> `data_o`=0x3C00020001, `mismatch_o`=0.
- Header mismatch: send flits 0xA51111, 0xB52222, 0xA500A5 -> `data_o`=0xA522221111, `mismatch_o`=1. The next clean message has `mismatch_o`=0, which shows the sticky error clears on flit 0.
- Gaps and illegal yumi: insert 2 idle cycles between each flit of the basic message and pulse `yumi_i` while `valid_o`=0 -> the result is identical to the basic case, with no spurious `valid_o`.
- Mid-message reset: send 2 flits, assert `reset_i`=0 for 1 cycle, then send the basic 3 flits -> the output is 0xA512345678, and there is no residue from the aborted message.
